// File: rtl/ro_window_sensor_if.sv
// ro_window_sensor_if: start/done measurement bundle; extSrc exists only with RO_EXT_SRC_EN
interface ro_window_sensor_if #(
  parameter int WINDOW_W = 16,
  parameter int COUNT_W = 24
);
  logic start;
  logic [WINDOW_W-1:0] windowLen;
  logic busy;
  logic done;
  logic [COUNT_W-1:0] count;
  logic overflow;
  logic roActive;
`ifdef RO_EXT_SRC_EN
  logic extSrc;
  modport master(output start, windowLen, extSrc, input busy, done, count, overflow, roActive);
  modport slave(input start, windowLen, extSrc, output busy, done, count, overflow, roActive);
`else
  modport master(output start, windowLen, input busy, done, count, overflow, roActive);
  modport slave(input start, windowLen, output busy, done, count, overflow, roActive);
`endif
endinterface

// File: rtl/ro_window_sensor.sv
// ro_window_sensor: gated ring oscillator counted over a clk window; RO_EXT_SRC_EN swaps the count source to extSrc
module ro_window_sensor #(
  parameter int N_STAGES = 63,
  parameter int WINDOW_W = 16,
  parameter int COUNT_W = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  ro_window_sensor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t state, stateNext;
  (* keep = 1 *) logic [N_STAGES-1:0] ring;
  logic src;
  logic [SYNC_STAGES-1:0] syncQ;
  logic syncPrev;
  logic rise;
  logic [WINDOW_W-1:0] timer;
  logic [WINDOW_W-1:0] winLen;
  logic lastTick;
  logic [COUNT_W-1:0] edgeCnt;
  logic [COUNT_W-1:0] countQ;
  logic sat;
  logic overflowQ;
  logic roActive;
  assign ring[0] = ~(roActive & ring[N_STAGES-1]);
  for (genvar i = 1; i < N_STAGES; i++) begin : g_inv
    assign ring[i] = ~ring[i-1];
  end
`ifdef RO_EXT_SRC_EN
  assign src = bus.extSrc;
`else
  assign src = ring[N_STAGES-1];
`endif
  assign rise = syncQ[SYNC_STAGES-1] & ~syncPrev;
  assign lastTick = timer == '0;
  assign roActive = state == ARM || state == RUN;
  assign bus.roActive = roActive;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.count = state == DONE ? edgeCnt : countQ;
  assign bus.overflow = state == DONE ? sat : overflowQ;
  // synchronize the asynchronous source and keep one older sample for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncQ <= '0;
      syncPrev <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], src};
      syncPrev <= syncQ[SYNC_STAGES-1];
    end
  end
  // next-state: ARM flushes the synchronizer, RUN spans the captured window
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = bus.start ? ARM : IDLE;
      ARM: stateNext = !lastTick ? ARM : winLen == '0 ? DONE : RUN;
      RUN: stateNext = lastTick ? DONE : RUN;
      default: stateNext = IDLE;
    endcase
  end
  // state register, phase timer, saturating edge counter and held results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      winLen <= '0;
      edgeCnt <= '0;
      sat <= 1'b0;
      countQ <= '0;
      overflowQ <= 1'b0;
    end else begin
      state <= stateNext;
      timer <= state == IDLE ? WINDOW_W'(SYNC_STAGES) : (state == ARM && lastTick) ? winLen - 1'b1 : timer - 1'b1;
      if (state == IDLE && bus.start) begin
        winLen <= bus.windowLen;
        edgeCnt <= '0;
        sat <= 1'b0;
      end
      if (state == RUN && rise) begin
        if (&edgeCnt) sat <= 1'b1;
        else edgeCnt <= edgeCnt + 1'b1;
      end
      if (state == DONE) begin
        countQ <= edgeCnt;
        overflowQ <= sat;
      end
    end
  end
endmodule

// File: tb/tb_ro_window_sensor.sv
// tb_ro_window_sensor: randomized run sequences against a window-level edge-count model, two counter widths
module tb_ro_window_sensor;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] windowLen = '0;
  logic extSrc = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit srcHist[int];
  bit active = 0;
  int startEdge = 0;
  int win = 0;
  int expRaw = 0;
  int srcMode = 0;
  int phase = 0;
  int d;

  ro_window_sensor_if b0();
  ro_window_sensor_if #(.COUNT_W(4)) b1();
  ro_window_sensor dut0(.clk(clk), .rst_n(rst_n), .bus(b0));
  ro_window_sensor #(.COUNT_W(4)) dut1(.clk(clk), .rst_n(rst_n), .bus(b1));
  assign b0.start = start;
  assign b1.start = start;
  assign b0.windowLen = windowLen;
  assign b1.windowLen = windowLen;
`ifdef RO_EXT_SRC_EN
  assign b0.extSrc = extSrc;
  assign b1.extSrc = extSrc;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Rising edges of the source over the counted samples of a run started at edge s0
  function automatic int rises(input int s0, input int w);
    int n = 0;
    for (int j = S + 1; j <= S + w; j++)
      if (srcHist[s0 + j] && !srcHist[s0 + j - 1]) n++;
    return n;
  endfunction

  // Reference model: run acceptance and result update, evaluated per clock edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    srcHist[cyc] = extSrc;
    if (!rst_n) begin
      active = 0;
      expRaw = 0;
    end else if ((!active || cyc - 1 - startEdge >= win + S + 3) && start) begin
      active = 1;
      startEdge = cyc;
      win = int'(windowLen);
    end
    if (active && cyc - startEdge == win + S + 2) expRaw = rises(startEdge, win);
  end

  // Compare every output of both instances against the model every cycle
  always @(negedge clk) if (cyc > 0) begin
    automatic int t = cyc - startEdge;
    automatic bit eBusy = active && t >= 1 && t <= win + S + 2;
    automatic bit eRo = active && t >= 1 && t <= win + S + 1;
    automatic bit eDone = active && t == win + S + 2;
    chk("busy0", b0.busy, eBusy);
    chk("roActive0", b0.roActive, eRo);
    chk("done0", b0.done, eDone);
    chk("count0", b0.count, expRaw);
    chk("overflow0", b0.overflow, 0);
    chk("busy1", b1.busy, eBusy);
    chk("roActive1", b1.roActive, eRo);
    chk("done1", b1.done, eDone);
    chk("count1", b1.count, expRaw > 15 ? 15 : expRaw);
    chk("overflow1", b1.overflow, expRaw > 15);
  end

  // Source generator: period-4 square wave, held level, or random per cycle
  initial forever begin
    @(posedge clk);
    #1;
    phase++;
    if (srcMode == 0) extSrc = (phase % 4) < 2;
    else if (srcMode == 2) extSrc = 1'($urandom_range(0, 1));
  end

  task automatic run(input int w, input int e1, input int e2, input int abortAt, input bit holdHigh, output int doneAt);
    doneAt = -1;
    @(posedge clk);
    #1;
    start = 1'b1;
    windowLen = 16'(w);
    if (holdHigh) extSrc = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    windowLen = 16'($urandom_range(0, 40));
    for (int c = 1; c <= w + 20 && doneAt < 0; c++) begin
      @(negedge clk);
      if (b0.done) doneAt = c;
      @(posedge clk);
      #1;
      start = (c + 1 == e1 || c + 1 == e2);
      rst_n = !(abortAt == c);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", b0.busy, 0);
    chk("reset_count", b0.count, 0);
    chk("reset_roActive", b0.roActive, 0);
`ifdef RO_EXT_SRC_EN
    run(100, 0, 0, 0, 0, d);
    chk("basic_doneAt", d, 104);
    chk("basic_count", b0.count, 25);
    chk("basic_overflow", b0.overflow, 0);
    chk("sat_count", b1.count, 15);
    chk("sat_overflow", b1.overflow, 1);
    run(20, 0, 0, 0, 0, d);
    chk("short_doneAt", d, 24);
    chk("short_count1", b1.count, 5);
    chk("short_overflow1", b1.overflow, 0);
    run(0, 0, 0, 0, 0, d);
    chk("zero_doneAt", d, 4);
    chk("zero_count", b0.count, 0);
    run(100, 10, 50, 0, 0, d);
    chk("busyStart_doneAt", d, 104);
    chk("busyStart_count", b0.count, 25);
    @(negedge clk);
    chk("afterDone_busy", b0.busy, 0);
    run(100, 0, 0, 40, 0, d);
    chk("abort_noDone", d, -1);
    chk("abort_count", b0.count, 0);
    run(100, 0, 0, 0, 0, d);
    chk("afterAbort_count", b0.count, 25);
    srcMode = 1;
    extSrc = 1'b0;
    repeat (6) @(posedge clk);
    run(30, 0, 0, 0, 1, d);
    chk("held_count", b0.count, 0);
    for (int k = 0; k < 30; k++) begin
      srcMode = $urandom_range(0, 2);
      if (srcMode == 1) extSrc = 1'($urandom_range(0, 1));
      run($urandom_range(0, 40), $urandom_range(0, 50), $urandom_range(0, 50),
          ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : 0, 1'($urandom_range(0, 1)), d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (60) @(posedge clk);
`else
    repeat (20) @(posedge clk);
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failed %0d", fails);
    $fatal(1);
  end
endmodule
